// File: rtl/mc_control_fsm.sv
// Multicycle RV32 control FSM with memory handshake, wait timeout and illegal-opcode trapping.
// Optional JALR support is enabled by defining JALR_EN; outputs are state-decoded and forced to 0 while resetn is low.
module mc_control_fsm #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TCNT_W         = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       zero,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pc_write,
    output logic       address_source,
    output logic       memory_write,
    output logic       ir_write,
    output logic       register_write,
    output logic [1:0] result_source,
    output logic [2:0] alu_control,
    output logic [1:0] alu_source_a,
    output logic [1:0] alu_source_b,
    output logic [2:0] immediate_source,
    output logic       instr_done,
    output logic       fault,
    output logic [1:0] fault_cause
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_JALR     = 4'd12,
        S_FAULT    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    state_t            state, state_next;
    logic [TCNT_W-1:0] wait_cnt;
    logic              fault_q;
    logic [1:0]        cause_q;
    logic              set_fault;
    logic [1:0]        set_cause;
    logic              timed_out;
    logic [2:0]        alu_dec;
    logic              alu_ok;

    logic       c_mem_req, c_pc_write, c_addr_src, c_mem_write, c_ir_write;
    logic       c_reg_write, c_done;
    logic [1:0] c_res_src, c_src_a, c_src_b;
    logic [2:0] c_alu, c_imm;

    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // Ready on the same cycle as the limit wins, hence the !mem_ready term.
    assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_cnt == TCNT_W'(TIMEOUT_CYCLES)) && !mem_ready;

    always_comb begin
        alu_ok  = 1'b1;
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b100:  alu_dec = ALU_XOR;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_next  = state;
        c_mem_req   = 1'b0;
        c_pc_write  = 1'b0;
        c_addr_src  = 1'b0;
        c_mem_write = 1'b0;
        c_ir_write  = 1'b0;
        c_reg_write = 1'b0;
        c_done      = 1'b0;
        c_res_src   = 2'b00;
        c_src_a     = 2'b00;
        c_src_b     = 2'b00;
        c_alu       = ALU_ADD;
        c_imm       = IMM_I;
        set_fault   = 1'b0;
        set_cause   = 2'b00;
        case (state)
            S_FETCH: begin
                c_mem_req  = 1'b1;
                c_src_b    = 2'b10;
                c_ir_write = mem_ready;
                c_pc_write = mem_ready;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timed_out) begin
                    state_next = S_FAULT;
                    set_fault  = 1'b1;
                    set_cause  = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                c_src_a = 2'b01;
                c_src_b = 2'b01;
                c_imm   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_I:              state_next = S_EXECI;
                    OP_BR:             state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_LUI:            state_next = S_LUI;
`ifdef JALR_EN
                    OP_JALR:           state_next = S_JALR;
`endif
                    default: begin
                        state_next = S_FAULT;
                        set_fault  = 1'b1;
                        set_cause  = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                c_src_a    = 2'b10;
                c_src_b    = 2'b01;
                c_imm      = opcode[5] ? IMM_S : IMM_I;
                state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                c_mem_req  = 1'b1;
                c_addr_src = 1'b1;
                c_res_src  = 2'b10;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timed_out) begin
                    state_next = S_FAULT;
                    set_fault  = 1'b1;
                    set_cause  = CAUSE_TIMEOUT;
                end
            end
            S_MEMWB: begin
                c_res_src   = 2'b01;
                c_reg_write = 1'b1;
                c_done      = 1'b1;
                state_next  = S_FETCH;
            end
            S_MEMWRITE: begin
                c_mem_req   = 1'b1;
                c_mem_write = 1'b1;
                c_addr_src  = 1'b1;
                c_res_src   = 2'b10;
                if (mem_ready) begin
                    c_done     = 1'b1;
                    state_next = S_FETCH;
                end else if (timed_out) begin
                    state_next = S_FAULT;
                    set_fault  = 1'b1;
                    set_cause  = CAUSE_TIMEOUT;
                end
            end
            S_EXECR, S_EXECI: begin
                c_src_a = 2'b10;
                c_src_b = (state == S_EXECI) ? 2'b01 : 2'b00;
                c_alu   = alu_dec;
                // funct7[5] selects sub only for register-register ops.
                if (state == S_EXECR && funct3 == 3'b000 && funct7[5]) begin
                    c_alu = ALU_SUB;
                end
                if (alu_ok) begin
                    state_next = S_ALUWB;
                end else begin
                    state_next = S_FAULT;
                    set_fault  = 1'b1;
                    set_cause  = CAUSE_ILLEGAL;
                end
            end
            S_ALUWB: begin
                c_res_src   = 2'b10;
                c_reg_write = 1'b1;
                c_done      = 1'b1;
                state_next  = S_FETCH;
            end
            S_BRANCH: begin
                c_src_a   = 2'b10;
                c_alu     = ALU_SUB;
                c_res_src = 2'b10;
                if (funct3[2:1] == 2'b00) begin
                    c_pc_write = zero ^ funct3[0];
                    c_done     = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_FAULT;
                    set_fault  = 1'b1;
                    set_cause  = CAUSE_ILLEGAL;
                end
            end
            S_JAL: begin
                c_src_a    = 2'b01;
                c_src_b    = 2'b10;
                c_res_src  = 2'b10;
                c_pc_write = 1'b1;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                c_src_a    = 2'b11;
                c_src_b    = 2'b01;
                c_imm      = IMM_U;
                state_next = S_ALUWB;
            end
`ifdef JALR_EN
            S_JALR: begin
                c_src_a    = 2'b10;
                c_src_b    = 2'b01;
                c_imm      = IMM_I;
                c_pc_write = 1'b1;
                state_next = S_ALUWB;
            end
`endif
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
            cause_q  <= 2'b00;
        end else begin
            state <= state_next;
            if (set_fault) begin
                fault_q <= 1'b1;
                cause_q <= set_cause;
            end
            if (c_mem_req && !mem_ready && state_next == state) begin
                if (wait_cnt != '1) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Gating with resetn drops strobes asynchronously, even though FETCH drives mem_req.
    assign mem_req          = resetn & c_mem_req;
    assign pc_write         = resetn & c_pc_write;
    assign address_source   = resetn & c_addr_src;
    assign memory_write     = resetn & c_mem_write;
    assign ir_write         = resetn & c_ir_write;
    assign register_write   = resetn & c_reg_write;
    assign instr_done       = resetn & c_done;
    assign result_source    = resetn ? c_res_src : 2'b00;
    assign alu_control      = resetn ? c_alu     : 3'b000;
    assign alu_source_a     = resetn ? c_src_a   : 2'b00;
    assign alu_source_b     = resetn ? c_src_b   : 2'b00;
    assign immediate_source = resetn ? c_imm     : 3'b000;
    assign fault            = fault_q;
    assign fault_cause      = cause_q;

endmodule
